// File: rtl/seg_scan_hex.sv
// Multiplexed hex seven-segment scanner with per-digit blank/blink/dp,
// global PWM brightness and frame-synchronised (tear-free) display updates.
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   load             : one-cycle strobe capturing data/dp/blank/blink/brightness
//   data, dp         : hex nibble and decimal point per digit
//   blank, blink     : per-digit dark and blink enables
//   brightness       : global duty, lit phases 0..brightness of 16
//   seg_sel, seg_led : registered digit enables and segments {dp,g..a}
//   pending          : staged values waiting for the next frame boundary
//   frame_done       : high during the cycle that ends a scan frame
module seg_scan_hex #(
   parameter int NUM_DIGITS     = 6,
   parameter int PRE_DIV        = 3125,
   parameter int BLINK_FRAMES   = 256,
   parameter int SEL_ACTIVE_LOW = 1,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   data,
   input  logic [NUM_DIGITS-1:0]     dp,
   input  logic [NUM_DIGITS-1:0]     blank,
   input  logic [NUM_DIGITS-1:0]     blink,
   input  logic [3:0]                brightness,
   output logic [NUM_DIGITS-1:0]     seg_sel,
   output logic [7:0]                seg_led,
   output logic                      pending,
   output logic                      frame_done
);

   localparam int PW = $clog2(PRE_DIV);
   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PW-1:0] PRE_LAST   = PW'(PRE_DIV - 1);
   localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIGITS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   localparam logic [NUM_DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [7:0]            LED_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      unique case (v)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         4'hF: s = 7'h71;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   logic [PW-1:0]           pre_cnt;
   logic [3:0]              phase;
   logic [DW-1:0]           dig;
   logic [BW-1:0]           blink_cnt;
   logic                    blink_on;

   logic [4*NUM_DIGITS-1:0] data_st, data_sh;
   logic [NUM_DIGITS-1:0]   dp_st, dp_sh;
   logic [NUM_DIGITS-1:0]   blank_st, blank_sh;
   logic [NUM_DIGITS-1:0]   blink_st, blink_sh;
   logic [3:0]              bright_st, bright_sh;

   logic                    phase_tick;
   logic                    digit_tick;
   logic                    frame_tick;
   logic                    lit;
   logic [3:0]              nib;
   logic [NUM_DIGITS-1:0]   sel_on;
   logic [7:0]              led_on;

   always_comb begin
      phase_tick = (pre_cnt == PRE_LAST);
      digit_tick = phase_tick && (phase == 4'hF);
      frame_tick = digit_tick && (dig == DIG_LAST);
      nib        = data_sh[4*int'(dig) +: 4];
      lit        = (phase <= bright_sh) && !blank_sh[dig]
                   && !(blink_sh[dig] && !blink_on);
      sel_on     = NUM_DIGITS'(1) << dig;
      led_on     = {dp_sh[dig], hex7(nib)};
   end

   assign frame_done = frame_tick;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         pre_cnt   <= '0;
         phase     <= '0;
         dig       <= '0;
         blink_cnt <= '0;
         blink_on  <= 1'b1;
         pending   <= 1'b0;
         data_st   <= '0;
         dp_st     <= '0;
         blank_st  <= '1;
         blink_st  <= '0;
         bright_st <= 4'hF;
         data_sh   <= '0;
         dp_sh     <= '0;
         blank_sh  <= '1;
         blink_sh  <= '0;
         bright_sh <= 4'hF;
         seg_sel   <= SEL_OFF;
         seg_led   <= LED_OFF;
      end else begin
         pre_cnt <= phase_tick ? '0 : pre_cnt + 1'b1;
         if (phase_tick)
            phase <= phase + 1'b1;
         if (digit_tick)
            dig <= frame_tick ? '0 : dig + 1'b1;

         // Shadow only changes here, so a frame never mixes old and new data.
         if (frame_tick) begin
            if (blink_cnt == BLINK_LAST) begin
               blink_cnt <= '0;
               blink_on  <= ~blink_on;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
            if (pending) begin
               data_sh   <= data_st;
               dp_sh     <= dp_st;
               blank_sh  <= blank_st;
               blink_sh  <= blink_st;
               bright_sh <= bright_st;
            end
         end

         // A load on the boundary cycle keeps pending set for the new staging.
         if (load) begin
            data_st   <= data;
            dp_st     <= dp;
            blank_st  <= blank;
            blink_st  <= blink;
            bright_st <= brightness;
            pending   <= 1'b1;
         end else if (frame_tick) begin
            pending   <= 1'b0;
         end

         seg_sel <= lit ? (sel_on ^ SEL_OFF) : SEL_OFF;
         seg_led <= lit ? (led_on ^ LED_OFF) : LED_OFF;
      end
   end

endmodule

// File: tb/tb_seg_scan_hex.sv
// Directed bench for seg_scan_hex: 4 digits, 2-cycle phases, 2-frame blink.
// Captures whole frames after frame_done and compares each digit slot.
module tb_seg_scan_hex;

   logic        clk = 1'b0;
   logic        sys_rst;
   logic        load;
   logic [15:0] data;
   logic [3:0]  dp;
   logic [3:0]  blank;
   logic [3:0]  blink;
   logic [3:0]  brightness;
   logic [3:0]  seg_sel;
   logic [7:0]  seg_led;
   logic        pending;
   logic        frame_done;

   logic [3:0]  sel_cap  [128];
   logic [7:0]  led_cap  [128];
   logic        fd_cap   [128];
   logic        pend_cap [128];

   int n_checks = 0;
   int n_fail   = 0;
   int cnt1 [4];
   logic p;

   always #5 clk = ~clk;

   seg_scan_hex #(
      .NUM_DIGITS(4),
      .PRE_DIV(2),
      .BLINK_FRAMES(2),
      .SEL_ACTIVE_LOW(1),
      .SEG_ACTIVE_LOW(1)
   ) dut (
      .sys_clk(clk),
      .sys_rst(sys_rst),
      .load(load),
      .data(data),
      .dp(dp),
      .blank(blank),
      .blink(blink),
      .brightness(brightness),
      .seg_sel(seg_sel),
      .seg_led(seg_led),
      .pending(pending),
      .frame_done(frame_done)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Returns at the negedge where frame_done is high.
   task automatic wait_fd(output logic pend);
      bit found;
      found = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (frame_done === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      check("frame_done seen", 32'(found), 32'd1);
      pend = pending;
   endtask

   // Sample c reflects frame cycle c (digit c/32, phase (c%32)/2).
   task automatic grab(input bit contig, output logic pend);
      pend = pending;
      if (!contig) begin
         wait_fd(pend);
         @(negedge clk);
      end
      for (int c = 0; c < 128; c++) begin
         @(negedge clk);
         sel_cap[c]  = seg_sel;
         led_cap[c]  = seg_led;
         fd_cap[c]   = frame_done;
         pend_cap[c] = pending;
      end
   endtask

   function automatic int lit_cnt(input int d);
      logic [3:0] on_sel;
      int n;
      on_sel = ~(4'b0001 << d);
      n = 0;
      for (int c = 32 * d; c < 32 * d + 32; c++)
         if (sel_cap[c] == on_sel) n++;
      return n;
   endfunction

   task automatic check_digit(input string tag, input int d,
                              input logic [7:0] led_exp, input int cnt_exp);
      logic [3:0] on_sel;
      int nl, nb;
      bit lit_s, dark_s, want;
      on_sel = ~(4'b0001 << d);
      nl = 0;
      nb = 0;
      for (int c = 32 * d; c < 32 * d + 32; c++) begin
         lit_s  = (sel_cap[c] == on_sel) && (led_cap[c] == led_exp);
         dark_s = (sel_cap[c] == 4'hF) && (led_cap[c] == 8'hFF);
         want   = (c - 32 * d) < cnt_exp;
         if (lit_s) nl++;
         if (want ? !lit_s : !dark_s) nb++;
      end
      check($sformatf("%s d%0d lit", tag, d), 32'(nl), 32'(cnt_exp));
      check($sformatf("%s d%0d bad", tag, d), 32'(nb), 32'd0);
   endtask

   task automatic check_fd(input string tag);
      int n, pos;
      n = 0;
      pos = -1;
      for (int c = 0; c < 128; c++)
         if (fd_cap[c]) begin
            n++;
            pos = c;
         end
      check({tag, " fd count"}, 32'(n), 32'd1);
      check({tag, " fd pos"}, 32'(pos), 32'd126);
   endtask

   task automatic pulse_load;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   initial begin
      sys_rst = 1'b1;
      load = 1'b0;
      data = '0;
      dp = '0;
      blank = '0;
      blink = '0;
      brightness = '0;
      repeat (3) @(negedge clk);
      check("rst sel", 32'(seg_sel), 32'hF);
      check("rst led", 32'(seg_led), 32'hFF);
      check("rst pending", 32'(pending), 32'd0);
      check("rst fd", 32'(frame_done), 32'd0);
      sys_rst = 1'b0;

      grab(1'b0, p);
      for (int d = 0; d < 4; d++) check_digit("idle", d, 8'hC0, 0);
      check_fd("idle");

      data = 16'h3210;
      blank = 4'h0;
      brightness = 4'd15;
      pulse_load();
      check("pending after load", 32'(pending), 32'd1);
      grab(1'b0, p);
      check("pending at fd", 32'(p), 32'd1);
      check("pending cleared", 32'(pend_cap[0]), 32'd0);
      check_digit("full", 0, 8'hC0, 32);
      check_digit("full", 1, 8'hF9, 32);
      check_digit("full", 2, 8'hA4, 32);
      check_digit("full", 3, 8'hB0, 32);
      check_fd("full");

      brightness = 4'd3;
      pulse_load();
      grab(1'b0, p);
      check_digit("dim", 0, 8'hC0, 8);
      check_digit("dim", 1, 8'hF9, 8);
      check_digit("dim", 2, 8'hA4, 8);
      check_digit("dim", 3, 8'hB0, 8);

      brightness = 4'd15;
      blink = 4'b0010;
      dp = 4'b0001;
      pulse_load();
      for (int f = 0; f < 4; f++) begin
         grab(f != 0, p);
         check_digit("blink", 0, 8'h40, 32);
         check_digit("blink", 2, 8'hA4, 32);
         check_digit("blink", 3, 8'hB0, 32);
         cnt1[f] = lit_cnt(1);
         check_digit("blink", 1, 8'hF9, (cnt1[f] != 0) ? 32 : 0);
         check_fd("blink");
      end
      check("blink on frames", 32'(cnt1[0] + cnt1[1] + cnt1[2] + cnt1[3]),
            32'd64);
      check("blink alt 0/2", 32'(cnt1[0] != cnt1[2]), 32'd1);
      check("blink alt 1/3", 32'(cnt1[1] != cnt1[3]), 32'd1);

      blink = 4'b0000;
      dp = 4'b0000;
      data = 16'h1111;
      pulse_load();
      wait_fd(p);
      data = 16'hFFFF;
      pulse_load();
      check("pending after coincident", 32'(pending), 32'd1);
      grab(1'b1, p);
      for (int d = 0; d < 4; d++) check_digit("old stage", d, 8'hF9, 32);
      check("pending before 2nd", 32'(pend_cap[126]), 32'd1);
      check("pending after 2nd", 32'(pend_cap[127]), 32'd0);
      grab(1'b1, p);
      for (int d = 0; d < 4; d++) check_digit("new stage", d, 8'h8E, 32);

      data = 16'h3210;
      pulse_load();
      repeat (10) @(negedge clk);
      check("pending pre-rst", 32'(pending), 32'd1);
      sys_rst = 1'b1;
      load = 1'b1;
      data = 16'h5555;
      @(negedge clk);
      check("midrst sel", 32'(seg_sel), 32'hF);
      check("midrst led", 32'(seg_led), 32'hFF);
      check("midrst pending", 32'(pending), 32'd0);
      sys_rst = 1'b0;
      load = 1'b0;
      grab(1'b0, p);
      for (int d = 0; d < 4; d++) check_digit("post rst", d, 8'hC0, 0);
      check("post rst pending", 32'(pend_cap[127]), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan_hex.md
SEG_SCAN_HEX -- requirements
Module: seg_scan_hex

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of multiplexed digits (1..16).
REQ-002 SHALL have parameter PRE_DIV, default 3125, sys_clk cycles per PWM phase (>=2).
REQ-003 SHALL have parameter BLINK_FRAMES, default 256, full scan frames per blink half-period (>=1).
REQ-004 SHALL have parameter SEL_ACTIVE_LOW, default 1, seg_sel polarity (1 = low enables digit).
REQ-005 SHALL have parameter SEG_ACTIVE_LOW, default 1, seg_led polarity (1 = low lights segment).
REQ-006 sys_clk  in  1  single clock; all logic on rising edge.
REQ-007 sys_rst  in  1  reset, synchronous, active-high.
REQ-008 load  in  1  one-cycle strobe capturing data/dp/blank/blink/brightness into staging.
REQ-009 data  in  4*NUM_DIGITS  hex nibbles, digit i = data[4i+3:4i].
REQ-010 dp  in  NUM_DIGITS  decimal point per digit.
REQ-011 blank  in  NUM_DIGITS  1 = digit dark.
REQ-012 blink  in  NUM_DIGITS  1 = digit dark during blink-off half-period.
REQ-013 brightness  in  4  global duty, 0 = 1/16, 15 = 16/16.
REQ-014 seg_sel  out  NUM_DIGITS  digit enables, one-hot or none, registered.
REQ-015 seg_led  out  8  segments {dp,g,f,e,d,c,b,a}, registered.
REQ-016 pending  out  1  staging not yet applied to display.
REQ-017 frame_done  out  1  one-cycle pulse at end of each full scan frame.

Function
REQ-018 Prescaler counts 0..PRE_DIV-1 and wraps; wrap cycle = phase tick.
REQ-019 4-bit phase counter increments on each phase tick; 15->0 wrap = digit tick.
REQ-020 Digit index increments on digit tick; NUM_DIGITS-1 -> 0 wrap = frame boundary, frame_done high that cycle only.
REQ-021 Blink counter counts frame boundaries 0..BLINK_FRAMES-1; on wrap blink_on toggles.
REQ-022 Current digit i is lit iff phase <= shadow brightness AND shadow blank[i]=0 AND NOT (shadow blink[i]=1 AND blink_on=0).
REQ-023 When lit: seg_sel has only bit i active; seg_led = hex code of shadow nibble i with bit 7 = shadow dp[i]; otherwise seg_sel all inactive and seg_led all off.
REQ-024 Active-high hex codes [6:0]: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; inverted (with dp) when SEG_ACTIVE_LOW=1.
REQ-025 seg_sel inverted when SEL_ACTIVE_LOW=1.
REQ-026 Outputs registered: seg_sel/seg_led reflect counter and shadow state of the previous cycle (latency 1).
REQ-027 load=1: staging <= inputs, pending <= 1; back-to-back loads overwrite staging, last wins.
REQ-028 Frame boundary with pending=1: shadow <= staging, pending <= 0; shadow never changes mid-frame (no tearing).
REQ-029 load coincident with frame boundary: shadow takes old staging, staging takes new inputs, pending stays 1.
REQ-030 Shadow writes at frame boundary take effect for digit 0 of the new frame (visible at outputs one cycle later).

Reset
REQ-031 sys_rst=1 forces next edge: prescaler, phase, digit index, blink counter = 0; blink_on = 1; pending = 0; frame_done = 0.
REQ-032 Reset values: staging and shadow data/dp/blink = 0, blank = all 1, brightness = 15; seg_sel all inactive, seg_led all off.
REQ-033 Reset mid-frame or with pending=1 discards staging contents; sys_rst overrides a coincident load.

Verification (NUM_DIGITS=4, PRE_DIV=2, BLINK_FRAMES=2, active-low polarity)
REQ-034 Release reset, no load -> seg_sel=4'hF, seg_led=8'hFF indefinitely; frame_done every 128 cycles.
REQ-035 load data=16'h3210, blank=0, brightness=15 mid-frame -> pending=1 until next frame_done; following frame seg_led=C0,F9,A4,B0 for digits 0..3, each 32 cycles, seg_sel=E,D,B,7.
REQ-036 brightness=3 -> each digit lit 8 cycles (phases 0..3), dark 24 cycles per slot.
REQ-037 blink=4'b0010 -> digit 1 lit 2 frames, dark 2 frames, repeating; other digits unaffected; dp=4'b0001 -> digit 0 seg_led bit7=0.
REQ-038 load asserted on frame_done cycle with data=16'hFFFF after earlier load 16'h1111 -> next frame shows 1111, frame after shows FFFF; pending clears only at second boundary.
REQ-039 Assert sys_rst mid-frame with pending=1 -> outputs dark next cycle, pending=0, display stays blank after release.
